sn_arbiter: RTL and testbench

Shares one snooper among `N_CORES` packetfilter cores. It picks a free core round-robin from their `rdy_for_sn` levels and offers one upstream `rdy_for_sn` to the snooper. It then routes the snooper's write/done traffic to that core until the packet's done handshake completes. It sits between the snooper and the array of packetfilter cores, and looks like a single core to the snooper.

---
 rtl/sn_arbiter.sv | 116 +++++++++++
 tb/tb_sn_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sn_arbiter.sv
// sn_arbiter: round-robin grant of one snooper to N packetfilter cores.
// Strobes are gated to the selected core; address/data are broadcast.
module sn_arbiter #(
  parameter int N_CORES           = 4,
  parameter int SEL_WIDTH         = 2,
  parameter int SN_FWD_ADDR_WIDTH = 8,
  parameter int SN_FWD_DATA_WIDTH = 64,
  parameter int INC_WIDTH         = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [SN_FWD_ADDR_WIDTH-1:0]           sn_addr,
  input  logic [SN_FWD_DATA_WIDTH-1:0]           sn_wr_data,
  input  logic                                   sn_wr_en,
  input  logic [INC_WIDTH-1:0]                   sn_byte_inc,
  input  logic                                   sn_done,
  output logic                                   sn_done_ack,
  output logic                                   rdy_for_sn,
  input  logic                                   rdy_for_sn_ack,
  output logic [N_CORES*SN_FWD_ADDR_WIDTH-1:0]   core_sn_addr,
  output logic [N_CORES*SN_FWD_DATA_WIDTH-1:0]   core_sn_wr_data,
  output logic [N_CORES*INC_WIDTH-1:0]           core_sn_byte_inc,
  output logic [N_CORES-1:0]                     core_sn_wr_en,
  output logic [N_CORES-1:0]                     core_sn_done,
  input  logic [N_CORES-1:0]                     core_sn_done_ack,
  input  logic [N_CORES-1:0]                     core_rdy_for_sn,
  output logic [N_CORES-1:0]                     core_rdy_for_sn_ack,
  output logic [SEL_WIDTH-1:0]                   sel,
  output logic [31:0]                            pkt_count
);

  localparam int SW1 = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH:0] NC = SW1'(N_CORES);

  typedef enum logic [1:0] {HUNT, OFFER, BUSY} state_t;

  state_t                 state;
  logic [SEL_WIDTH-1:0]   last;
  logic [SEL_WIDTH-1:0]   pick;
  logic [SEL_WIDTH:0]     shamt;
  logic [SEL_WIDTH:0]     p;
  logic [2*N_CORES-1:0]   dbl;
  logic [N_CORES-1:0]     rot;
  logic                   found;
  logic                   done_hs;

  // rot[0] is core last+1, so the lowest set bit is the next in turn
  assign dbl   = {core_rdy_for_sn, core_rdy_for_sn};
  assign shamt = {1'b0, last} + {{SEL_WIDTH{1'b0}}, 1'b1};
  assign rot   = N_CORES'(dbl >> shamt);

  always_comb begin
    found = 1'b0;
    p     = '0;
    for (int i = N_CORES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        p     = {1'b0, last} + SW1'(i + 1);
      end
    end
    pick = SEL_WIDTH'((p >= NC) ? (p - NC) : p);
  end

  assign done_hs = (state == BUSY) && sn_done && core_sn_done_ack[sel];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      last      <= SEL_WIDTH'(N_CORES - 1);
      sel       <= '0;
      pkt_count <= '0;
    end else begin
      unique case (state)
        HUNT: begin
          if (found) begin
            sel   <= pick;
            state <= OFFER;
          end
        end
        OFFER: begin
          if (rdy_for_sn_ack) state <= BUSY;
        end
        BUSY: begin
          if (done_hs) begin
            last      <= sel;
            pkt_count <= pkt_count + 32'd1;
            state     <= HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign rdy_for_sn = (state == OFFER);

  always_comb begin
    core_sn_wr_en       = '0;
    core_sn_done        = '0;
    core_rdy_for_sn_ack = '0;
    sn_done_ack         = 1'b0;
    if (state == BUSY) begin
      core_sn_wr_en[sel] = sn_wr_en;
      core_sn_done[sel]  = sn_done;
      sn_done_ack        = core_sn_done_ack[sel];
    end
    if (state == OFFER) begin
      core_rdy_for_sn_ack[sel] = rdy_for_sn_ack;
    end
  end

  assign core_sn_addr     = {N_CORES{sn_addr}};
  assign core_sn_wr_data  = {N_CORES{sn_wr_data}};
  assign core_sn_byte_inc = {N_CORES{sn_byte_inc}};

endmodule

// File: tb/tb_sn_arbiter.sv
// tb_sn_arbiter: vector table plus directed multi-cycle sequences
// for the round-robin snooper arbiter.
module tb_sn_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    sn_addr;
  logic [63:0]   sn_wr_data;
  logic          sn_wr_en;
  logic [3:0]    sn_byte_inc;
  logic          sn_done;
  logic          sn_done_ack;
  logic          rdy_for_sn;
  logic          rdy_for_sn_ack;
  logic [31:0]   core_sn_addr;
  logic [255:0]  core_sn_wr_data;
  logic [15:0]   core_sn_byte_inc;
  logic [3:0]    core_sn_wr_en;
  logic [3:0]    core_sn_done;
  logic [3:0]    core_sn_done_ack;
  logic [3:0]    core_rdy_for_sn;
  logic [3:0]    core_rdy_for_sn_ack;
  logic [1:0]    sel;
  logic [31:0]   pkt_count;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sn_arbiter dut (
    .clk                 (clk),
    .rst                 (rst),
    .sn_addr             (sn_addr),
    .sn_wr_data          (sn_wr_data),
    .sn_wr_en            (sn_wr_en),
    .sn_byte_inc         (sn_byte_inc),
    .sn_done             (sn_done),
    .sn_done_ack         (sn_done_ack),
    .rdy_for_sn          (rdy_for_sn),
    .rdy_for_sn_ack      (rdy_for_sn_ack),
    .core_sn_addr        (core_sn_addr),
    .core_sn_wr_data     (core_sn_wr_data),
    .core_sn_byte_inc    (core_sn_byte_inc),
    .core_sn_wr_en       (core_sn_wr_en),
    .core_sn_done        (core_sn_done),
    .core_sn_done_ack    (core_sn_done_ack),
    .core_rdy_for_sn     (core_rdy_for_sn),
    .core_rdy_for_sn_ack (core_rdy_for_sn_ack),
    .sel                 (sel),
    .pkt_count           (pkt_count)
  );

  typedef struct {
    logic [3:0]  crdy;
    logic        ack;
    logic        wr;
    logic        done;
    logic [3:0]  cdack;
    logic        rfs;
    logic [1:0]  sel;
    logic [3:0]  cwr;
    logic [3:0]  cdone;
    logic [3:0]  crack;
    logic        sdack;
    logic [31:0] pkt;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic zero_in();
    sn_wr_en         = 1'b0;
    sn_done          = 1'b0;
    rdy_for_sn_ack   = 1'b0;
    core_sn_done_ack = 4'h0;
    core_rdy_for_sn  = 4'h0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_rfs"}, {31'd0, rdy_for_sn}, 32'd0);
    chk({nm, "_strb"}, {16'd0, core_sn_wr_en, core_sn_done,
        core_rdy_for_sn_ack, 3'd0, sn_done_ack}, 32'd0);
    chk({nm, "_sel"}, {30'd0, sel}, 32'd0);
    chk({nm, "_pkt"}, pkt_count, 32'd0);
  endtask

  // Called at a negedge; leaves rst released at the next negedge.
  task automatic do_reset(input string nm);
    rst = 1'b0;
    zero_in();
    #1;
    chk_idle(nm);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Called at a negedge; returns at negedge+1 of the OFFER cycle.
  task automatic wait_rfs(input string nm);
    int n = 0;
    #1;
    while (!rdy_for_sn && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(nm, {31'd0, rdy_for_sn}, 32'd1);
  endtask

  task automatic run_pkt(input string nm, input logic [1:0] g,
                         input int nwr);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    wait_rfs({nm, "_rdy"});
    chk({nm, "_sel"}, {30'd0, sel}, {30'd0, g});
    rdy_for_sn_ack = 1'b1;
    #1;
    chk({nm, "_crack"}, {28'd0, core_rdy_for_sn_ack}, {28'd0, oh});
    @(negedge clk);
    rdy_for_sn_ack = 1'b0;
    for (int w = 0; w < nwr; w++) begin
      sn_wr_en = 1'b1;
      #1;
      chk({nm, "_cwr"}, {28'd0, core_sn_wr_en}, {28'd0, oh});
      @(negedge clk);
      sn_wr_en = 1'b0;
      #1;
      chk({nm, "_cwr_lo"}, {28'd0, core_sn_wr_en}, 32'd0);
      @(negedge clk);
    end
    sn_done          = 1'b1;
    core_sn_done_ack = 4'hF;
    #1;
    chk({nm, "_sdack"}, {31'd0, sn_done_ack}, 32'd1);
    chk({nm, "_cdone"}, {28'd0, core_sn_done}, {28'd0, oh});
    @(negedge clk);
    sn_done          = 1'b0;
    core_sn_done_ack = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pk0;
    int bad;

    tv[0]  = '{4'hF,1'b0,1'b0,1'b0,4'h0, 1'b0,2'd0,4'h0,4'h0,4'h0,1'b0,32'd0};
    tv[1]  = '{4'hF,1'b1,1'b0,1'b0,4'h0, 1'b1,2'd0,4'h0,4'h0,4'h1,1'b0,32'd0};
    tv[2]  = '{4'hF,1'b0,1'b1,1'b0,4'h0, 1'b0,2'd0,4'h1,4'h0,4'h0,1'b0,32'd0};
    tv[3]  = '{4'hF,1'b0,1'b1,1'b1,4'h0, 1'b0,2'd0,4'h1,4'h1,4'h0,1'b0,32'd0};
    tv[4]  = '{4'hF,1'b0,1'b0,1'b1,4'h1, 1'b0,2'd0,4'h0,4'h1,4'h0,1'b1,32'd0};
    tv[5]  = '{4'hF,1'b1,1'b1,1'b1,4'hF, 1'b0,2'd0,4'h0,4'h0,4'h0,1'b0,32'd1};
    tv[6]  = '{4'hF,1'b0,1'b1,1'b0,4'h0, 1'b1,2'd1,4'h0,4'h0,4'h0,1'b0,32'd1};
    tv[7]  = '{4'hF,1'b1,1'b0,1'b0,4'h0, 1'b1,2'd1,4'h0,4'h0,4'h2,1'b0,32'd1};
    tv[8]  = '{4'hF,1'b0,1'b0,1'b1,4'hF, 1'b0,2'd1,4'h0,4'h2,4'h0,1'b1,32'd1};
    tv[9]  = '{4'h0,1'b0,1'b0,1'b0,4'h0, 1'b0,2'd1,4'h0,4'h0,4'h0,1'b0,32'd2};
    tv[10] = '{4'h1,1'b0,1'b0,1'b0,4'h0, 1'b0,2'd1,4'h0,4'h0,4'h0,1'b0,32'd2};
    tv[11] = '{4'h0,1'b1,1'b0,1'b0,4'h0, 1'b1,2'd0,4'h0,4'h0,4'h1,1'b0,32'd2};
    tv[12] = '{4'h0,1'b0,1'b0,1'b1,4'h1, 1'b0,2'd0,4'h0,4'h1,4'h0,1'b1,32'd2};
    tv[13] = '{4'h4,1'b0,1'b0,1'b0,4'h0, 1'b0,2'd0,4'h0,4'h0,4'h0,1'b0,32'd3};
    tv[14] = '{4'h0,1'b0,1'b0,1'b0,4'h0, 1'b1,2'd2,4'h0,4'h0,4'h0,1'b0,32'd3};

    rst         = 1'b0;
    sn_addr     = 8'h00;
    sn_wr_data  = 64'h0;
    sn_byte_inc = 4'h0;
    zero_in();
    repeat (2) @(negedge clk);
    #1;
    chk_idle("reset");

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      core_rdy_for_sn  = tv[i].crdy;
      rdy_for_sn_ack   = tv[i].ack;
      sn_wr_en         = tv[i].wr;
      sn_done          = tv[i].done;
      core_sn_done_ack = tv[i].cdack;
      #1;
      chk($sformatf("v%0d_rfs", i), {31'd0, rdy_for_sn}, {31'd0, tv[i].rfs});
      chk($sformatf("v%0d_sel", i), {30'd0, sel}, {30'd0, tv[i].sel});
      chk($sformatf("v%0d_cwr", i), {28'd0, core_sn_wr_en},
          {28'd0, tv[i].cwr});
      chk($sformatf("v%0d_cdone", i), {28'd0, core_sn_done},
          {28'd0, tv[i].cdone});
      chk($sformatf("v%0d_crack", i), {28'd0, core_rdy_for_sn_ack},
          {28'd0, tv[i].crack});
      chk($sformatf("v%0d_sdack", i), {31'd0, sn_done_ack},
          {31'd0, tv[i].sdack});
      chk($sformatf("v%0d_pkt", i), pkt_count, tv[i].pkt);
      @(negedge clk);
    end

    sn_addr     = 8'hA5;
    sn_wr_data  = 64'h0123_4567_89AB_CDEF;
    sn_byte_inc = 4'h9;
    #1;
    chk("bcast_addr", core_sn_addr, 32'hA5A5_A5A5);
    chk("bcast_inc", {16'd0, core_sn_byte_inc}, 32'h0000_9999);
    chk("bcast_data", {31'd0, core_sn_wr_data[255:192] == sn_wr_data &&
        core_sn_wr_data[63:0] == sn_wr_data}, 32'd1);
    @(negedge clk);

    // Round-robin with every core always ready
    do_reset("rr_rst");
    core_rdy_for_sn = 4'hF;
    for (int k = 0; k < 5; k++) begin
      run_pkt($sformatf("rr%0d", k), 2'(k % 4), 3);
    end
    #1;
    chk("rr_pkt", pkt_count, 32'd5);
    @(negedge clk);

    // Skip cores that are not ready
    do_reset("skip_rst");
    core_rdy_for_sn = 4'h1;
    run_pkt("skip_c0", 2'd0, 1);
    core_rdy_for_sn = 4'h4;
    run_pkt("skip_c2", 2'd2, 1);
    core_rdy_for_sn = 4'h2;
    run_pkt("skip_c1", 2'd1, 1);

    // No core ready, stray ack, then core 3 appears
    do_reset("none_rst");
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rdy_for_sn !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("none_rfs_cycles", bad, 32'd0);
    rdy_for_sn_ack = 1'b1;
    #1;
    chk("stray_crack", {28'd0, core_rdy_for_sn_ack}, 32'd0);
    @(negedge clk);
    rdy_for_sn_ack  = 1'b0;
    core_rdy_for_sn = 4'h8;
    #1;
    chk("c3_rfs_t0", {31'd0, rdy_for_sn}, 32'd0);
    @(negedge clk);
    #1;
    chk("c3_rfs_t1", {31'd0, rdy_for_sn}, 32'd1);
    chk("c3_sel", {30'd0, sel}, 32'd3);

    // Done held four cycles, acked on the fourth
    rdy_for_sn_ack = 1'b1;
    @(negedge clk);
    rdy_for_sn_ack = 1'b0;
    sn_done        = 1'b1;
    bad            = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (sn_done_ack !== 1'b0 || core_sn_done !== 4'h8) bad++;
      @(negedge clk);
    end
    chk("hold_early", bad, 32'd0);
    core_sn_done_ack = 4'h8;
    #1;
    chk("hold_ack4", {31'd0, sn_done_ack}, 32'd1);
    pk0 = pkt_count;
    @(negedge clk);
    sn_done          = 1'b0;
    core_sn_done_ack = 4'h0;
    #1;
    chk("hold_hunt_rfs", {31'd0, rdy_for_sn}, 32'd0);
    chk("hold_pkt", pkt_count, pk0 + 32'd1);
    @(negedge clk);
    #1;
    chk("hold_next_rfs", {31'd0, rdy_for_sn}, 32'd1);
    chk("hold_next_sel", {30'd0, sel}, 32'd3);

    // Reset asserted mid-packet
    rdy_for_sn_ack = 1'b1;
    @(negedge clk);
    rdy_for_sn_ack = 1'b0;
    sn_wr_en       = 1'b1;
    sn_done        = 1'b1;
    #1;
    chk("mid_cwr", {28'd0, core_sn_wr_en}, 32'h8);
    rst = 1'b0;
    #1;
    core_sn_done_ack = 4'h8;
    rdy_for_sn_ack   = 1'b1;
    #1;
    chk_idle("mid_rst");
    @(negedge clk);
    zero_in();
    core_rdy_for_sn = 4'hF;
    rst             = 1'b1;
    wait_rfs("mid_rdy");
    chk("mid_sel", {30'd0, sel}, 32'd0);
    chk("mid_pkt", pkt_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
